// File: rtl/pipelined_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit_pkg
// Description : Opcode, ALU and mux-select encodings plus the control bundle
//               carried down the D/E/M/W pipeline.
// Revision    : 1.0
// ============================================================================
package pipelined_control_unit_pkg;

    localparam logic [6:0] c_op_lw     = 7'b0000011;
    localparam logic [6:0] c_op_sw     = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    localparam logic [1:0] c_res_alu = 2'b00;
    localparam logic [1:0] c_res_mem = 2'b01;
    localparam logic [1:0] c_res_pc4 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       branch;
        logic       branchneg;
        logic       jump;
        logic [2:0] alucontrol;
        logic       alusrc;
    } ctrl_t;

    // Returns {legal, alucontrol} for the arithmetic funct3 values we implement.
    function automatic logic [3:0] f_alu_sel(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return {1'b1, (sub ? c_alu_sub : c_alu_add)};
            3'b010:  return {1'b1, c_alu_slt};
            3'b110:  return {1'b1, c_alu_or};
            3'b111:  return {1'b1, c_alu_and};
            default: return {1'b0, c_alu_add};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit_if
// Description : Datapath <-> control-unit signal bundle.
// Revision    : 1.0
// ============================================================================
interface pipelined_control_unit_if;
    logic [31:0] InstrD;
    logic        ZeroE;
    logic        FlushE;
    logic [1:0]  ImmSrcD;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic        PCSrcE;
    logic        ResultSrcE0;
    logic        MemWriteM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW;
    logic        IllegalD;
    logic        IllegalSeen;

    modport master (
        output InstrD, ZeroE, FlushE,
        input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0,
               MemWriteM, RegWriteM, ResultSrcW, RegWriteW, IllegalD, IllegalSeen
    );

    modport slave (
        input  InstrD, ZeroE, FlushE,
        output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0,
               MemWriteM, RegWriteM, ResultSrcW, RegWriteW, IllegalD, IllegalSeen
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : control_decoder
// Description : Combinational decode of the D-stage instruction into a
//               control bundle; unsupported encodings yield a bubble.
// Revision    : 1.0
// ============================================================================
module control_decoder
    import pipelined_control_unit_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  wire logic [31:0] i_instr,
    output ctrl_t            o_ctrl,
    output logic [1:0]       o_immsrc,
    output logic             o_illegal
);

    logic [6:0] w_op;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    ctrl_t      w_ctrl;
    logic [1:0] w_imm;
    logic       w_illegal;
    logic [3:0] w_alu_sel;
    logic       w_unused;

    assign w_op     = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    // Sub only exists for R-type; addi with imm[10]=1 must stay an add.
    assign w_alu_sel = f_alu_sel(w_funct3, (w_op == c_op_rtype) && w_funct7[5]);

    always_comb begin
        w_ctrl    = '0;
        w_imm     = c_imm_i;
        w_illegal = 1'b0;
        case (w_op)
            c_op_lw: begin
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.resultsrc  = c_res_mem;
                w_ctrl.alucontrol = c_alu_add;
                w_illegal         = (w_funct3 != 3'b010);
            end
            c_op_sw: begin
                w_ctrl.memwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = c_alu_add;
                w_imm             = c_imm_s;
                w_illegal         = (w_funct3 != 3'b010);
            end
            c_op_rtype: begin
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.resultsrc  = c_res_alu;
                w_ctrl.alucontrol = w_alu_sel[2:0];
                w_illegal         = !w_alu_sel[3] || !((w_funct7 == 7'h00) || (w_funct7 == 7'h20));
            end
            c_op_itype: begin
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = w_alu_sel[2:0];
                w_illegal         = !w_alu_sel[3];
            end
            c_op_branch: begin
                w_ctrl.branch     = 1'b1;
                w_ctrl.branchneg  = w_funct3[0];
                w_ctrl.alucontrol = c_alu_sub;
                w_imm             = c_imm_b;
                w_illegal         = !((w_funct3 == 3'b000) || (SUPPORT_BNE && (w_funct3 == 3'b001)));
            end
            c_op_jal: begin
                w_ctrl.jump      = 1'b1;
                w_ctrl.regwrite  = 1'b1;
                w_ctrl.resultsrc = c_res_pc4;
                w_imm            = c_imm_j;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign o_ctrl    = w_illegal ? '0 : w_ctrl;
    assign o_immsrc  = w_illegal ? c_imm_i : w_imm;
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : Decodes in D and carries controls through D/E, E/M and M/W
//               registers; E-stage flush and sticky illegal-opcode flag.
// Revision    : 1.0
// ============================================================================
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  wire logic               CLK,
    input  wire logic               RST_N,
    pipelined_control_unit_if.slave bus
);

    ctrl_t      w_ctrl_d;
    logic [1:0] w_immsrc_d;
    logic       w_illegal_d;

    ctrl_t      r_ctrl_e;
    logic       r_regwrite_m;
    logic [1:0] r_resultsrc_m;
    logic       r_memwrite_m;
    logic       r_regwrite_w;
    logic [1:0] r_resultsrc_w;
    logic       r_illegal_seen;

    control_decoder #(
        .SUPPORT_BNE (SUPPORT_BNE)
    ) u_decoder (
        .i_instr   (bus.InstrD),
        .o_ctrl    (w_ctrl_d),
        .o_immsrc  (w_immsrc_d),
        .o_illegal (w_illegal_d)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ctrl_e       <= '0;
            r_regwrite_m   <= 1'b0;
            r_resultsrc_m  <= 2'b00;
            r_memwrite_m   <= 1'b0;
            r_regwrite_w   <= 1'b0;
            r_resultsrc_w  <= 2'b00;
            r_illegal_seen <= 1'b0;
        end else begin
            r_ctrl_e       <= bus.FlushE ? '0 : w_ctrl_d;
            r_regwrite_m   <= r_ctrl_e.regwrite;
            r_resultsrc_m  <= r_ctrl_e.resultsrc;
            r_memwrite_m   <= r_ctrl_e.memwrite;
            r_regwrite_w   <= r_regwrite_m;
            r_resultsrc_w  <= r_resultsrc_m;
            // A flushed illegal instruction never really executed, so it is not recorded.
            if (w_illegal_d && !bus.FlushE) begin
                r_illegal_seen <= 1'b1;
            end
        end
    end

    assign bus.ImmSrcD     = w_immsrc_d;
    assign bus.IllegalD    = w_illegal_d;
    assign bus.ALUControlE = r_ctrl_e.alucontrol;
    assign bus.ALUSrcE     = r_ctrl_e.alusrc;
    assign bus.PCSrcE      = r_ctrl_e.jump | (r_ctrl_e.branch & (bus.ZeroE ^ r_ctrl_e.branchneg));
    assign bus.ResultSrcE0 = r_ctrl_e.resultsrc[0];
    assign bus.MemWriteM   = r_memwrite_m;
    assign bus.RegWriteM   = r_regwrite_m;
    assign bus.ResultSrcW  = r_resultsrc_w;
    assign bus.RegWriteW   = r_regwrite_w;
    assign bus.IllegalSeen = r_illegal_seen;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Directed + random stimulus against a reference decode model,
//               with per-stage expectation queues drained by a monitor.
// Revision    : 1.0
// ============================================================================
module tb_pipelined_control_unit;

    localparam int NDIR  = 10;
    localparam int NRAND = 400;
    localparam int NCYC  = NDIR + NRAND;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    pipelined_control_unit_if bus();

    pipelined_control_unit #(.SUPPORT_BNE(1'b1)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ill;
        logic [1:0] imm;
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       br;
        logic       bneg;
        logic       jmp;
        logic [2:0] alu;
        logic       asrc;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] q_d[$];   // {ImmSrcD, IllegalD, IllegalSeen}
    logic [5:0] q_e[$];   // {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}
    logic [1:0] q_m[$];   // {MemWriteM, RegWriteM}
    logic [2:0] q_w[$];   // {RegWriteW, ResultSrcW}

    logic [31:0] d_instr [NDIR] = '{32'h002081B3, 32'h402081B3, 32'h0000A283, 32'h0050A223,
                                    32'h00208463, 32'h00208463, 32'h00208463, 32'h008000EF,
                                    32'hFFFFFFFF, 32'h002081B3};
    logic        d_flush [NDIR] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic        d_zero  [NDIR] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics written straight from the ISA subset's rules.
    function automatic exp_t model(input logic [31:0] instr);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        op = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
        e  = '0;
        ok = 1'b0;
        if (op == 7'h03 && f3 == 3'd2) begin
            ok = 1; e.rw = 1; e.asrc = 1; e.rs = 2'b01; e.imm = 2'b00;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            ok = 1; e.mw = 1; e.asrc = 1; e.imm = 2'b01;
        end else if ((op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) || op == 7'h13) begin
            e.rw = 1; e.asrc = (op == 7'h13);
            ok = 1;
            if (f3 == 3'd0)      e.alu = (op == 7'h33 && f7 == 7'h20) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) e.alu = 3'd5;
            else if (f3 == 3'd6) e.alu = 3'd3;
            else if (f3 == 3'd7) e.alu = 3'd2;
            else                 ok = 0;
        end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            ok = 1; e.br = 1; e.bneg = (f3 == 3'd1); e.alu = 3'd1; e.imm = 2'b10;
        end else if (op == 7'h6F) begin
            ok = 1; e.jmp = 1; e.rw = 1; e.rs = 2'b10; e.imm = 2'b11;
        end
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
        logic [6:0] op;
        logic [6:0] f7;
        logic [31:0] r;
        r  = $urandom;
        op = ops[$urandom_range(0, 6)];
        if (op == 7'h00) op = 7'($urandom);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, r[24:7], op};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_alu"},    32'(bus.ALUControlE), 0);
        check({tag, "_asrc"},   32'(bus.ALUSrcE),     0);
        check({tag, "_pcsrc"},  32'(bus.PCSrcE),      0);
        check({tag, "_rse0"},   32'(bus.ResultSrcE0), 0);
        check({tag, "_memwm"},  32'(bus.MemWriteM),   0);
        check({tag, "_regwm"},  32'(bus.RegWriteM),   0);
        check({tag, "_regww"},  32'(bus.RegWriteW),   0);
        check({tag, "_rsw"},    32'(bus.ResultSrcW),  0);
        check({tag, "_seen"},   32'(bus.IllegalSeen), 0);
    endtask

    task automatic stimulus();
        exp_t        e, b, prev;
        logic        seen;
        logic        flush, zero;
        logic [31:0] instr;
        seen = 1'b0;
        prev = '0;
        for (int n = 0; n < NCYC; n++) begin
            @(negedge CLK);
            instr = (n < NDIR) ? d_instr[n] : gen_instr();
            flush = (n < NDIR) ? d_flush[n] : ($urandom_range(0, 7) == 0);
            zero  = (n >= 1 && n - 1 < NDIR) ? d_zero[n-1] : 1'($urandom_range(0, 1));
            RST_N      = 1'b1;
            bus.InstrD = instr;
            bus.FlushE = flush;
            bus.ZeroE  = zero;
            e = model(instr);
            b = flush ? '0 : e;
            q_d.push_back({e.imm, e.ill, seen});
            if (n >= 1)
                q_e.push_back({prev.alu, prev.asrc,
                               prev.jmp | (prev.br & (prev.bneg ? !zero : zero)), prev.rs[0]});
            q_m.push_back({b.mw, b.rw});
            q_w.push_back({b.rw, b.rs});
            if (e.ill && !flush) seen = 1'b1;
            prev = b;
        end
    endtask

    task automatic monitor();
        for (int n = 0; n < NCYC; n++) begin
            @(negedge CLK);
            #2;
            if (q_d.size() == 0) check("q_d_empty", 1, 0);
            else check("D", {bus.ImmSrcD, bus.IllegalD, bus.IllegalSeen}, q_d.pop_front());
            if (n >= 1) begin
                if (q_e.size() == 0) check("q_e_empty", 1, 0);
                else check("E", {bus.ALUControlE, bus.ALUSrcE, bus.PCSrcE, bus.ResultSrcE0},
                           q_e.pop_front());
            end
            if (n >= 2) begin
                if (q_m.size() == 0) check("q_m_empty", 1, 0);
                else check("M", {bus.MemWriteM, bus.RegWriteM}, q_m.pop_front());
            end
            if (n >= 3) begin
                if (q_w.size() == 0) check("q_w_empty", 1, 0);
                else check("W", {bus.RegWriteW, bus.ResultSrcW}, q_w.pop_front());
            end
        end
    endtask

    initial begin
        bus.InstrD = 32'h00000013;
        bus.FlushE = 1'b0;
        bus.ZeroE  = 1'b0;
        #1 RST_N = 1'b0;
        #3 check_reset("rst");

        fork
            stimulus();
            monitor();
        join

        // Fill the pipe with legal adds, then pull reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.InstrD = 32'h002081B3;
            bus.FlushE = 1'b0;
        end
        @(negedge CLK);
        #2;
        check("pre_rst_regww", 32'(bus.RegWriteW),   1);
        check("pre_rst_seen",  32'(bus.IllegalSeen), 1);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1 check_reset("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
